dffram_host_if: RTL and testbench
=================================

Name: dffram_host_if

Overview:
- Initiator-side controller for the single-port 32-bit DFFRAM macro.
- Converts an Ibex-style data-bus request/grant/rvalid interface into the macro's EN/WE/DI/A strobes.
- Returns the macro's registered DO as bus read data.
- Also provides a hardware zeroize sequencer that clears every word. It sits between the core/crossbar data port and the RAM macro.

Parameters:
- AW, 12, RAM word-address width; DEPTH = 2**AW words.
- BASE_ADDR, 32'h1000_0000, byte base address of the RAM window; must be aligned to 4*DEPTH.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_i  input  1  bus request.
- gnt_o  output  1  bus grant; request accepted this cycle.
- we_i  input  1  1 = write, 0 = read.
- be_i  input  4  byte enables for writes.
- addr_i  input  32  byte address.
- wdata_i  input  32  write data.
- rvalid_o  output  1  response valid; exactly one per grant.
- rdata_o  output  32  read data; valid with rvalid_o.
- err_o  output  1  response error; valid with rvalid_o.
- init_i  input  1  zeroize request pulse.
- init_busy_o  output  1  zeroize in progress.
- init_done_o  output  1  one-cycle pulse when zeroize completes.
- ram_en_o  output  1  to macro EN.
- ram_we_o  output  4  to macro WE.
- ram_di_o  output  32  to macro DI.
- ram_a_o  output  AW  to macro A.
- ram_do_i  input  32  from macro DO; registered, one cycle after EN.

Behaviour:
- Reset values: state = IDLE; rvalid_o, err_o, init_busy_o, init_done_o = 0; rdata_o = 0; counter = 0. All ram_* outputs are 0 while rst_i is asserted.
- FSM states: IDLE (serve bus), INIT (zeroize).
- IDLE to INIT: init_i = 1 in IDLE. This takes priority over a same-cycle req_i, which gets gnt_o = 0.
- INIT to IDLE: after the write to word DEPTH-1.
- init_i is ignored while in INIT.
- Grant: gnt_o = req_i when state = IDLE and init_i = 0, combinationally; else gnt_o = 0. No request buffering; a requester holds its request until granted.
- In-range access (addr_i[31:AW+2] == BASE_ADDR[31:AW+2]), on grant:
  - ram_en_o = 1.
  - ram_a_o = addr_i[AW+1:2].
  - ram_we_o = we_i ? be_i : 4'h0.
  - ram_di_o = wdata_i.
  - addr_i[1:0] is ignored.
- Write with be_i = 0: still enables the RAM, no bytes change, normal response.
- Out-of-range access, on grant: ram_en_o = 0; the response carries err_o = 1 and rdata_o = 0.
- Response timing: rvalid_o rises exactly one cycle after the grant cycle and lasts one cycle. Back-to-back grants give back-to-back rvalid.
- Read response: rdata_o = ram_do_i in the rvalid cycle.
- Write and error responses: rdata_o = 0.
- rdata_o is 0 whenever rvalid_o = 0.
- Zeroize: in INIT, each cycle drives ram_en_o = 1, ram_we_o = 4'hF, ram_di_o = 0, ram_a_o = counter, then increments the counter.
  - On counter = DEPTH-1: counter wraps to 0, state returns to IDLE, init_done_o pulses in the next cycle.
  - init_busy_o = 1 for exactly the DEPTH cycles of INIT.
  - Zeroize never asserts rvalid_o.
- A response pending from the grant cycle immediately before entering INIT still completes normally in the first INIT cycle.
- Reset mid-operation (including mid-INIT): asynchronously returns to reset values and discards pending responses. The zeroize is not resumed except as set by the optional feature.

Optional Feature:
- Macro: DFFRAM_HOST_INIT_ON_RESET_EN.
- Defined: on reset deassertion the FSM leaves reset in INIT and zeroizes all DEPTH words; init_busy_o = 1 and gnt_o = 0 until done, and init_done_o pulses at completion.
- Undefined: leaves reset in IDLE; RAM contents are untouched (preload survives); zeroize occurs only on init_i.

Test Plan:
- Write addr 0x1000_0010, be 4'hF, wdata 0xDEAD_BEEF; then read the same address.
  - Write: gnt same cycle; ram_a_o = 4, ram_we_o = 4'hF; rvalid next cycle with rdata 0.
  - Read: rvalid one cycle after its grant with rdata 0xDEAD_BEEF.
- Byte-masked write be 4'b0101, wdata 0x1122_3344 over 0xDEAD_BEEF at word 4 -> subsequent read returns 0xDE22_BE44.
- Out-of-range read addr 0x2000_0000 -> gnt = 1, ram_en_o = 0, next-cycle rvalid = 1, err_o = 1, rdata 0.
- Pulse init_i with req_i held high:
  - gnt_o = 0 for 4096 cycles; ram_we_o = 4'hF with addresses 0..4095.
  - init_done_o pulses once; then gnt resumes.
  - Reading word 4 returns 0.
- Four back-to-back reads of words 0..3 preloaded 0xA0..0xA3 -> four consecutive rvalid cycles returning 0xA0, 0xA1, 0xA2, 0xA3 in order.
- Assert rst_i at zeroize cycle 100 -> outputs go to reset values immediately; words 100..4095 keep old data (macro undefined); with DFFRAM_HOST_INIT_ON_RESET_EN, a full 4096-cycle zeroize restarts at 0.

Source files
------------

// File: rtl/dffram_host_if.sv
// rtl/dffram_host_if.sv - Ibex-style data-bus front end and zeroize sequencer for the single-port DFFRAM macro.
// Optional: DFFRAM_HOST_INIT_ON_RESET_EN starts a full zeroize on reset release.
module dffram_host_if #(
   parameter int          AW        = 12,
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req_i,
   output logic          gnt_o,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [31:0]   addr_i,
   input  logic [31:0]   wdata_i,
   output logic          rvalid_o,
   output logic [31:0]   rdata_o,
   output logic          err_o,
   input  logic          init_i,
   output logic          init_busy_o,
   output logic          init_done_o,
   output logic          ram_en_o,
   output logic [3:0]    ram_we_o,
   output logic [31:0]   ram_di_o,
   output logic [AW-1:0] ram_a_o,
   input  logic [31:0]   ram_do_i
);

   typedef enum logic {IDLE, INIT} state_t;

`ifdef DFFRAM_HOST_INIT_ON_RESET_EN
   localparam state_t RST_STATE = INIT;
`else
   localparam state_t RST_STATE = IDLE;
`endif

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          rvalid_q, rvalid_d;
   logic          err_q, err_d;
   logic          rd_q, rd_d;
   logic          done_q, done_d;

   logic          in_range;
   logic          gnt;
   logic          en;
   logic [3:0]    we;
   logic [31:0]   di;
   logic [AW-1:0] a;
   logic          unused_addr_lsb;

   assign in_range        = (addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
   assign unused_addr_lsb = ^addr_i[1:0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      rd_d     = 1'b0;
      done_d   = 1'b0;
      gnt      = 1'b0;
      en       = 1'b0;
      we       = 4'h0;
      di       = 32'h0;
      a        = '0;
      case (state_q)
         IDLE: begin
            // A zeroize request wins over a same-cycle bus request.
            if (init_i) begin
               state_d = INIT;
            end else if (req_i) begin
               gnt      = 1'b1;
               rvalid_d = 1'b1;
               if (in_range) begin
                  en   = 1'b1;
                  a    = addr_i[AW+1:2];
                  we   = we_i ? be_i : 4'h0;
                  di   = wdata_i;
                  rd_d = ~we_i;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         INIT: begin
            en    = 1'b1;
            we    = 4'hF;
            a     = cnt_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {AW{1'b1}}) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= RST_STATE;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rd_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rd_q     <= rd_d;
         done_q   <= done_d;
      end
   end

   // Combinational strobes are forced quiet while reset is held so the macro never sees a stray write.
   assign gnt_o       = gnt & ~rst_i;
   assign ram_en_o    = en & ~rst_i;
   assign ram_we_o    = rst_i ? 4'h0 : we;
   assign ram_di_o    = rst_i ? 32'h0 : di;
   assign ram_a_o     = rst_i ? '0 : a;
   assign init_busy_o = (state_q == INIT) & ~rst_i;
   assign init_done_o = done_q;
   assign rvalid_o    = rvalid_q;
   assign err_o       = err_q;
   assign rdata_o     = (rvalid_q && rd_q) ? ram_do_i : 32'h0;

endmodule

// File: tb/tb_dffram_host_if.sv
// tb/tb_dffram_host_if.sv - Directed vector bench for dffram_host_if with a behavioural DFFRAM model.
module tb_dffram_host_if;

   localparam int DEPTH = 4096;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i, we_i, init_i;
   logic [3:0]  be_i;
   logic [31:0] addr_i, wdata_i;
   logic        gnt_o, rvalid_o, err_o, init_busy_o, init_done_o;
   logic [31:0] rdata_o;
   logic        ram_en_o;
   logic [3:0]  ram_we_o;
   logic [31:0] ram_di_o;
   logic [11:0] ram_a_o;
   logic [31:0] ram_do_i;

   logic [31:0] mem [0:DEPTH-1];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   dffram_host_if #(.AW(12), .BASE_ADDR(32'h1000_0000)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
      .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
      .rdata_o(rdata_o), .err_o(err_o), .init_i(init_i), .init_busy_o(init_busy_o),
      .init_done_o(init_done_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
      .ram_di_o(ram_di_o), .ram_a_o(ram_a_o), .ram_do_i(ram_do_i)
   );

   always @(posedge clk_i) begin
      if (ram_en_o) begin
         ram_do_i <= mem[ram_a_o];
         for (int b = 0; b < 4; b++)
            if (ram_we_o[b]) mem[ram_a_o][8*b +: 8] <= ram_di_o[8*b +: 8];
      end
   end

   typedef struct {
      logic        req, we;
      logic [3:0]  be;
      logic [31:0] addr, wdata;
      logic        e_gnt, e_en;
      logic [3:0]  e_we;
      logic [11:0] e_a;
      logic        e_rv, e_err;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs [17];

   function automatic logic [31:0] pat(int i);
      return 32'h5500_0000 | 32'(i);
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic req, logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] wdata, logic init);
      req_i = req; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata; init_i = init;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_i);
   endtask

   task automatic preload();
      for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
      mem[0] <= 32'hA0; mem[1] <= 32'hA1; mem[2] <= 32'hA2; mem[3] <= 32'hA3;
      step();
   endtask

   // Called at the sampling point of the first INIT cycle; ends at the sampling point of the cycle after done.
   task automatic zeroize_check(string name, logic exp_gnt_after);
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if ({gnt_o, ram_en_o, ram_we_o, ram_a_o, ram_di_o, init_busy_o, rvalid_o, init_done_o} !==
             {1'b0, 1'b1, 4'hF, 12'(i), 32'h0, 1'b1, 1'b0, 1'b0}) bad++;
         step(); sample();
      end
      chk({name, "_seq"}, 64'(bad), 64'd0);
      chk({name, "_done"}, {61'd0, init_done_o, init_busy_o, gnt_o}, {61'd0, 1'b1, 1'b0, exp_gnt_after});
      step(); sample();
      chk({name, "_done_once"}, {63'd0, init_done_o}, 64'd0);
   endtask

   initial begin
      rst_i = 1'b1;
      drive(1'b1, 1'b1, 4'hF, 32'h1000_0010, 32'h1234_5678, 1'b1);
      preload();
      sample();
      chk("reset_outputs",
          {14'd0, gnt_o, ram_en_o, ram_we_o, ram_a_o, rvalid_o, err_o, init_busy_o, init_done_o, rdata_o},
          64'd0);
      chk("reset_di", {32'd0, ram_di_o}, 64'd0);
      step();
      rst_i = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      sample();
`ifdef DFFRAM_HOST_INIT_ON_RESET_EN
      zeroize_check("por_zeroize", 1'b0);
      chk("por_mem_last", {32'd0, mem[DEPTH-1]}, 64'd0);
      preload();
`else
      chk("post_reset_idle", {63'd0, init_busy_o}, 64'd0);
`endif

      vecs[0]  = '{1, 1, 4'hF, 32'h1000_0010, 32'hDEAD_BEEF, 1, 1, 4'hF, 12'd4, 0, 0, 32'h0};
      vecs[1]  = '{1, 0, 4'h0, 32'h1000_0010, 32'h0,         1, 1, 4'h0, 12'd4, 1, 0, 32'h0};
      vecs[2]  = '{1, 1, 4'h5, 32'h1000_0012, 32'h1122_3344, 1, 1, 4'h5, 12'd4, 1, 0, 32'hDEAD_BEEF};
      vecs[3]  = '{1, 0, 4'hF, 32'h1000_0010, 32'h0,         1, 1, 4'h0, 12'd4, 1, 0, 32'h0};
      vecs[4]  = '{1, 0, 4'h0, 32'h2000_0000, 32'h0,         1, 0, 4'h0, 12'd0, 1, 0, 32'hDE22_BE44};
      vecs[5]  = '{1, 0, 4'h0, 32'h1000_0000, 32'h0,         1, 1, 4'h0, 12'd0, 1, 1, 32'h0};
      vecs[6]  = '{1, 0, 4'h0, 32'h1000_0004, 32'h0,         1, 1, 4'h0, 12'd1, 1, 0, 32'hA0};
      vecs[7]  = '{1, 0, 4'h0, 32'h1000_0008, 32'h0,         1, 1, 4'h0, 12'd2, 1, 0, 32'hA1};
      vecs[8]  = '{1, 0, 4'h0, 32'h1000_000C, 32'h0,         1, 1, 4'h0, 12'd3, 1, 0, 32'hA2};
      vecs[9]  = '{0, 0, 4'h0, 32'h1000_0000, 32'h0,         0, 0, 4'h0, 12'd0, 1, 0, 32'hA3};
      vecs[10] = '{0, 0, 4'h0, 32'h1000_0000, 32'h0,         0, 0, 4'h0, 12'd0, 0, 0, 32'h0};
      vecs[11] = '{1, 1, 4'h0, 32'h1000_0020, 32'hFFFF_FFFF, 1, 1, 4'h0, 12'd8, 0, 0, 32'h0};
      vecs[12] = '{0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 4'h0, 12'd0, 1, 0, 32'h0};
      vecs[13] = '{1, 0, 4'h0, 32'h1000_0020, 32'h0,         1, 1, 4'h0, 12'd8, 0, 0, 32'h0};
      vecs[14] = '{0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 4'h0, 12'd0, 1, 0, 32'h5500_0008};
      vecs[15] = '{1, 1, 4'hF, 32'h0FFF_FFFC, 32'h0,         1, 0, 4'h0, 12'd0, 0, 0, 32'h0};
      vecs[16] = '{0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 4'h0, 12'd0, 1, 1, 32'h0};

      for (int v = 0; v < 17; v++) begin
         step();
         drive(vecs[v].req, vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata, 1'b0);
         sample();
         chk($sformatf("vec%0d", v),
             {12'd0, gnt_o, ram_en_o, ram_we_o, ram_a_o, rvalid_o, err_o, rdata_o},
             {12'd0, vecs[v].e_gnt, vecs[v].e_en, vecs[v].e_we, vecs[v].e_a,
              vecs[v].e_rv, vecs[v].e_err, vecs[v].e_rdata});
      end

      // Zeroize with the bus request held; a read granted just before still completes.
      step(); drive(1'b1, 1'b0, 4'h0, 32'h1000_0004, 32'h0, 1'b0); sample();
      chk("pre_init_gnt", {63'd0, gnt_o}, 64'd1);
      step(); drive(1'b1, 1'b0, 4'h0, 32'h1000_0004, 32'h0, 1'b1); sample();
      chk("init_prio", {28'd0, gnt_o, ram_en_o, rvalid_o, rdata_o},
          {28'd0, 1'b0, 1'b0, 1'b1, 32'hA1});
      step(); drive(1'b1, 1'b0, 4'h0, 32'h1000_0004, 32'h0, 1'b0); sample();
      zeroize_check("zeroize", 1'b1);
      chk("post_init_rd1", {31'd0, rvalid_o, rdata_o}, {31'd0, 1'b1, 32'h0});
      step(); drive(1'b1, 1'b0, 4'h0, 32'h1000_0010, 32'h0, 1'b0); sample();
      step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0); sample();
      chk("post_init_rd4", {31'd0, rvalid_o, rdata_o}, {31'd0, 1'b1, 32'h0});
      chk("zeroize_last_word", {32'd0, mem[DEPTH-1]}, 64'd0);

      // Reset in the middle of a zeroize.
      preload();
      step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      repeat (100) step();
      chk("mid_init_addr", {52'd0, ram_a_o}, 64'd100);
      rst_i = 1'b1;
      #1;
      chk("mid_init_reset",
          {20'd0, gnt_o, ram_en_o, ram_we_o, ram_a_o, init_busy_o, init_done_o, rvalid_o, err_o, rdata_o},
          64'd0);
      repeat (2) step();
      rst_i = 1'b0;
      sample();
      chk("partial_zeroed", {32'd0, mem[99]}, 64'd0);
`ifdef DFFRAM_HOST_INIT_ON_RESET_EN
      zeroize_check("restart_zeroize", 1'b0);
      chk("restart_word100", {32'd0, mem[100]}, 64'd0);
      chk("restart_last", {32'd0, mem[DEPTH-1]}, 64'd0);
`else
      chk("no_resume_busy", {63'd0, init_busy_o}, 64'd0);
      chk("kept_word100", {32'd0, mem[100]}, {32'd0, pat(100)});
      chk("kept_last", {32'd0, mem[DEPTH-1]}, {32'd0, pat(DEPTH-1)});
      step(); drive(1'b1, 1'b0, 4'h0, 32'h1000_0190, 32'h0, 1'b0); sample();
      step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0); sample();
      chk("kept_word100_rd", {31'd0, rvalid_o, rdata_o}, {31'd0, 1'b1, pat(100)});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
